// File: rtl/fixed_point_acc.sv
// fixed_point_acc: streaming sign-magnitude accumulator.
// Sums a framed stream of sign-magnitude terms (MSB = sign) and emits one
// registered result per frame together with a sticky overflow flag and a
// saturating beat count. Sits after the multiplier array as the per-neuron
// dot-product reducer.
module fixed_point_acc #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  localparam int MW = WIDTH - 1;
  localparam logic [MW-1:0]    MAG_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic             acc_sign;
  logic [MW-1:0]    acc_mag;
  logic             sat_flag;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             in_sign;
  logic [MW-1:0]    in_mag;
  logic [MW:0]      mag_sum;
  logic             raw_sign;
  logic [MW-1:0]    raw_mag;
  logic             sum_sign;
  logic [MW-1:0]    sum_mag;
  logic             sum_ovf;
  logic [CNT_W-1:0] count_next;

  // No terms are taken while a finished result is waiting downstream.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // A zero magnitude is always carried as +0, so 8000h behaves as 0000h.
  assign in_mag  = in_data[MW-1:0];
  assign in_sign = in_data[MW] && (in_mag != '0);

  // The beat counter sticks at its maximum instead of wrapping.
  assign count_next = (count == CNT_MAX) ? count : count + CNT_ONE;

  // Sign-magnitude add of the incoming term onto the running accumulator.
  always_comb begin
    mag_sum  = {1'b0, acc_mag} + {1'b0, in_mag};
    raw_sign = acc_sign;
    raw_mag  = mag_sum[MW-1:0];
    sum_ovf  = 1'b0;
    if (acc_sign == in_sign) begin
      if (mag_sum[MW]) begin
        sum_ovf = 1'b1;
        raw_mag = SATURATE ? MAG_MAX : mag_sum[MW-1:0];
      end
    end else if (acc_mag >= in_mag) begin
      raw_mag = acc_mag - in_mag;
    end else begin
      raw_sign = in_sign;
      raw_mag  = in_mag - acc_mag;
    end
    sum_mag  = raw_mag;
    sum_sign = raw_sign && (raw_mag != '0);
  end

  // Frame FSM: first beat loads, later beats accumulate, HOLD presents the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_sign  <= 1'b0;
      acc_mag   <= '0;
      sat_flag  <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_sign <= in_sign;
            acc_mag  <= in_mag;
            count    <= CNT_ONE;
            sat_flag <= 1'b0;
            if (in_last) begin
              out_data  <= {in_sign, in_mag};
              out_sat   <= 1'b0;
              out_count <= CNT_ONE;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_sign <= sum_sign;
            acc_mag  <= sum_mag;
            count    <= count_next;
            sat_flag <= sat_flag | sum_ovf;
            if (in_last) begin
              out_data  <= {sum_sign, sum_mag};
              out_sat   <= sat_flag | sum_ovf;
              out_count <= count_next;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
